// File: rtl/issue_credit_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// issue_credit_ctrl_pkg
//
// Definitions shared by the issue-side flow controller and its neighbours
// (dispatcher, ROB, register file):
//   - OPC_LOAD / OPC_STORE : major opcodes that route to the load/store buffer
//   - RENAMED_ZERO         : reserved ROB alias, never handed to an instruction
//   - ROB_ID_W             : ROB id width for the default ROB size
//   - issue_state_e        : issue FSM states {RUN, DRAIN}
//   - is_ls_op()           : classifies an opcode as load/store
// -----------------------------------------------------------------------------
package issue_credit_ctrl_pkg;

    localparam int ROB_SIZE_DEFAULT = 16;
    localparam int ROB_ID_W         = $clog2(ROB_SIZE_DEFAULT);

    // Alias 0 means "not renamed" to the register file, so it is never issued.
    localparam int RENAMED_ZERO = 0;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } issue_state_e;

    function automatic logic is_ls_op(input logic [6:0] opcode);
        return (opcode == OPC_LOAD) || (opcode == OPC_STORE);
    endfunction

endpackage

// File: rtl/issue_credit_ctrl_credit_counter.sv
// -----------------------------------------------------------------------------
// credit_counter
//
// Free-slot credit counter for one back-end structure. Starts full (MAX),
// loses one credit on take_i, regains one on release_i, and returns to full
// on reload_i. A simultaneous take and release leave the count unchanged.
// A release while already full saturates at MAX.
//
// Ports:
//   clk        clock
//   rst_n      asynchronous active-low reset (count -> MAX)
//   take_i     consume one credit (caller guarantees nonzero_o was high)
//   release_i  return one credit
//   reload_i   restore all credits; dominates take/release
//   cnt_o      current credit count, $clog2(MAX)+1 bits
//   nonzero_o  at least one credit available
// -----------------------------------------------------------------------------
module credit_counter
    import issue_credit_ctrl_pkg::*;
#(
    parameter int MAX = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   take_i,
    input  logic                   release_i,
    input  logic                   reload_i,
    output logic [$clog2(MAX):0]   cnt_o,
    output logic                   nonzero_o
);

    localparam int            W     = $clog2(MAX) + 1;
    localparam logic [W-1:0]  MAX_V = W'(MAX);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned and infers a latch.
    always_comb begin
        cnt_d = cnt_q;
        if (reload_i) begin
            cnt_d = MAX_V;
        end else if (take_i && !release_i) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - 1'b1;
            end
        end else if (release_i && !take_i) begin
            // Releasing into a full counter is a producer bug; hold at MAX.
            if (cnt_q != MAX_V) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge value regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= MAX_V;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o     = cnt_q;
    assign nonzero_o = (cnt_q != '0);

endmodule

// File: rtl/issue_credit_ctrl.sv
// -----------------------------------------------------------------------------
// issue_credit_ctrl
//
// Issue-side flow controller between fetcher and dispatcher. Tracks free
// slots in the ROB, reservation station and load/store buffer, grants a
// fetched instruction only when every structure it needs has a credit, and
// hands out the ROB alias for it. After a rollback it holds grant low for
// FLUSH_CYCLES cycles while the back end drains.
//
// Parameters:
//   ROB_SIZE      ROB entries (alias 0 reserved -> capacity ROB_SIZE-1)
//   RS_SIZE       reservation-station entries
//   LSB_SIZE      load/store-buffer entries
//   FLUSH_CYCLES  grant-blocking cycles after rollback, 1..7
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   rdy               global ready; low freezes all state and blocks grant
//   rollback_signal   misprediction flush from the ROB
//   fet_valid         fetcher holds an instruction
//   fet_opcode        instr[6:0] of that instruction
//   issue_grant       instruction accepted this cycle
//   alias_2disp       ROB id for the granted instruction
//   rob_commit        one ROB entry retired
//   rs_release        one RS entry issued
//   lsb_release       one LSB entry completed
//   stall_rob/rs/lsb  debug stall reasons while fet_valid in RUN
//
// Optional build macro ISSUE_CTRL_STATS_EN adds 32-bit wrapping event
// counters stat_grants, stat_stall_rob, stat_stall_rs, stat_stall_lsb and
// stat_flushes, cleared only by reset.
// -----------------------------------------------------------------------------
module issue_credit_ctrl
    import issue_credit_ctrl_pkg::*;
#(
    parameter int ROB_SIZE     = 16,
    parameter int RS_SIZE      = 16,
    parameter int LSB_SIZE     = 16,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        rdy,
    input  logic                        rollback_signal,
    input  logic                        fet_valid,
    input  logic [6:0]                  fet_opcode,
    output logic                        issue_grant,
    output logic [$clog2(ROB_SIZE)-1:0] alias_2disp,
    input  logic                        rob_commit,
    input  logic                        rs_release,
    input  logic                        lsb_release,
    output logic                        stall_rob,
    output logic                        stall_rs,
    output logic                        stall_lsb
`ifdef ISSUE_CTRL_STATS_EN
    ,
    output logic [31:0]                 stat_grants,
    output logic [31:0]                 stat_stall_rob,
    output logic [31:0]                 stat_stall_rs,
    output logic [31:0]                 stat_stall_lsb,
    output logic [31:0]                 stat_flushes
`endif
);

    localparam int              ID_W        = $clog2(ROB_SIZE);
    localparam logic [ID_W-1:0] ALIAS_FIRST = ID_W'(RENAMED_ZERO + 1);
    localparam logic [ID_W-1:0] ALIAS_LAST  = ID_W'(ROB_SIZE - 1);
    localparam logic [2:0]      DRAIN_LOAD  = 3'(FLUSH_CYCLES - 1);

    // -------------------------------------------------------------------------
    // Classification and credit counters
    // -------------------------------------------------------------------------
    logic is_ls;
    logic rob_nz, rs_nz, lsb_nz;
    logic [$clog2(ROB_SIZE - 1):0] rob_cnt;
    logic [$clog2(RS_SIZE):0]      rs_cnt;
    logic [$clog2(LSB_SIZE):0]     lsb_cnt;

    issue_state_e state_q, state_d;
    logic [2:0]   drain_q, drain_d;
    logic [ID_W-1:0] alias_q, alias_d;

    logic release_ok;
    logic reload;

    assign is_ls = is_ls_op(fet_opcode);

    // Releases only count in normal RUN cycles; a rollback refills everything
    // anyway, so late releases from flushed work must not be double counted.
    assign release_ok = rdy && (state_q == RUN) && !rollback_signal;
    assign reload     = rdy && rollback_signal;

    credit_counter #(.MAX(ROB_SIZE - 1)) u_rob_credit (
        .clk       (clk),
        .rst_n     (rst_n),
        .take_i    (issue_grant),
        .release_i (release_ok && rob_commit),
        .reload_i  (reload),
        .cnt_o     (rob_cnt),
        .nonzero_o (rob_nz)
    );

    credit_counter #(.MAX(RS_SIZE)) u_rs_credit (
        .clk       (clk),
        .rst_n     (rst_n),
        .take_i    (issue_grant && !is_ls),
        .release_i (release_ok && rs_release),
        .reload_i  (reload),
        .cnt_o     (rs_cnt),
        .nonzero_o (rs_nz)
    );

    credit_counter #(.MAX(LSB_SIZE)) u_lsb_credit (
        .clk       (clk),
        .rst_n     (rst_n),
        .take_i    (issue_grant && is_ls),
        .release_i (release_ok && lsb_release),
        .reload_i  (reload),
        .cnt_o     (lsb_cnt),
        .nonzero_o (lsb_nz)
    );

    // -------------------------------------------------------------------------
    // Issue FSM: next state and grant/stall outputs
    // -------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        drain_d     = drain_q;
        issue_grant = 1'b0;
        stall_rob   = 1'b0;
        stall_rs    = 1'b0;
        stall_lsb   = 1'b0;

        if (rdy) begin
            if (rollback_signal) begin
                // A rollback in DRAIN restarts the window as well.
                state_d = DRAIN;
                drain_d = DRAIN_LOAD;
            end else if (state_q == DRAIN) begin
                if (drain_q == '0) begin
                    state_d = RUN;
                end else begin
                    drain_d = drain_q - 1'b1;
                end
            end
        end

        // Outputs are forced low while reset is held, not just after an edge.
        if (rst_n && (state_q == RUN)) begin
            issue_grant = rdy && !rollback_signal && fet_valid && rob_nz &&
                          (is_ls ? lsb_nz : rs_nz);
            stall_rob   = fet_valid && (rob_cnt == '0);
            stall_rs    = fet_valid && !is_ls && (rs_cnt == '0);
            stall_lsb   = fet_valid && is_ls && (lsb_cnt == '0);
        end
    end

    // NOTE: all control registers take the asynchronous reset so the block
    // leaves reset in a defined state without needing a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
        end
    end

    // -------------------------------------------------------------------------
    // ROB alias pointer: cycles 1..ROB_SIZE-1, skipping the reserved alias 0
    // -------------------------------------------------------------------------
    always_comb begin
        alias_d = alias_q;
        if (rdy) begin
            if (rollback_signal) begin
                alias_d = ALIAS_FIRST;
            end else if (issue_grant) begin
                alias_d = (alias_q == ALIAS_LAST) ? ALIAS_FIRST : alias_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alias_q <= ALIAS_FIRST;
        end else begin
            alias_q <= alias_d;
        end
    end

    assign alias_2disp = alias_q;

`ifdef ISSUE_CTRL_STATS_EN
    // -------------------------------------------------------------------------
    // Event statistics; survive rollback, cleared only by reset
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_grants    <= '0;
            stat_stall_rob <= '0;
            stat_stall_rs  <= '0;
            stat_stall_lsb <= '0;
            stat_flushes   <= '0;
        end else if (rdy) begin
            if (issue_grant)     stat_grants    <= stat_grants + 32'd1;
            if (stall_rob)       stat_stall_rob <= stat_stall_rob + 32'd1;
            if (stall_rs)        stat_stall_rs  <= stat_stall_rs + 32'd1;
            if (stall_lsb)       stat_stall_lsb <= stat_stall_lsb + 32'd1;
            if (rollback_signal) stat_flushes   <= stat_flushes + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_issue_credit_ctrl.sv
// -----------------------------------------------------------------------------
// tb_issue_credit_ctrl
//
// Self-checking bench for issue_credit_ctrl (ROB 16, RS 16, LSB 8, flush 2).
// A behavioural model tracks free slots as plain integers and the drain
// window as a count of remaining ready cycles; every cycle's outputs are
// compared against it. A vector table and hand sequences cover the directed
// corner cases, followed by a randomized run.
// -----------------------------------------------------------------------------
module tb_issue_credit_ctrl;

    localparam int ROB_SIZE     = 16;
    localparam int RS_SIZE      = 16;
    localparam int LSB_SIZE     = 8;
    localparam int FLUSH_CYCLES = 2;
    localparam int ID_W         = $clog2(ROB_SIZE);

    localparam logic [6:0] OP_RS = 7'b0110011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            rdy = 1'b0;
    logic            rollback_signal = 1'b0;
    logic            fet_valid = 1'b0;
    logic [6:0]      fet_opcode = OP_RS;
    logic            rob_commit = 1'b0;
    logic            rs_release = 1'b0;
    logic            lsb_release = 1'b0;
    logic            issue_grant;
    logic [ID_W-1:0] alias_2disp;
    logic            stall_rob, stall_rs, stall_lsb;
`ifdef ISSUE_CTRL_STATS_EN
    logic [31:0] stat_grants, stat_stall_rob, stat_stall_rs, stat_stall_lsb, stat_flushes;
`endif

    issue_credit_ctrl #(
        .ROB_SIZE     (ROB_SIZE),
        .RS_SIZE      (RS_SIZE),
        .LSB_SIZE     (LSB_SIZE),
        .FLUSH_CYCLES (FLUSH_CYCLES)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .rdy             (rdy),
        .rollback_signal (rollback_signal),
        .fet_valid       (fet_valid),
        .fet_opcode      (fet_opcode),
        .issue_grant     (issue_grant),
        .alias_2disp     (alias_2disp),
        .rob_commit      (rob_commit),
        .rs_release      (rs_release),
        .lsb_release     (lsb_release),
        .stall_rob       (stall_rob),
        .stall_rs        (stall_rs),
        .stall_lsb       (stall_lsb)
`ifdef ISSUE_CTRL_STATS_EN
        ,
        .stat_grants     (stat_grants),
        .stat_stall_rob  (stat_stall_rob),
        .stat_stall_rs   (stat_stall_rs),
        .stat_stall_lsb  (stat_stall_lsb),
        .stat_flushes    (stat_flushes)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------------
    // Behavioural model: free slots per structure, next alias, and the
    // number of ready cycles still to spend draining after a rollback.
    // ---------------------------------------------------------------------
    int m_rob, m_rs, m_lsb, m_alias, m_hold;

    task automatic model_reset();
        m_rob   = ROB_SIZE - 1;
        m_rs    = RS_SIZE;
        m_lsb   = LSB_SIZE;
        m_alias = 1;
        m_hold  = 0;
    endtask

    // Outputs sampled in the most recent step, for directed checks.
    logic            s_grant, s_srob, s_srs, s_slsb;
    logic [ID_W-1:0] s_alias;

    // One clock cycle: drive inputs, sample mid-cycle, compare with the
    // model, advance the model, then move past the rising edge.
    task automatic step(input bit r, input bit rb, input bit fv, input logic [6:0] opc,
                        input bit cm, input bit rsr, input bit lsr);
        bit run, ls, eg;
        rdy = r; rollback_signal = rb; fet_valid = fv; fet_opcode = opc;
        rob_commit = cm; rs_release = rsr; lsb_release = lsr;
        @(negedge clk);
        run = (m_hold == 0);
        ls  = (opc == OP_LD) || (opc == OP_ST);
        eg  = run && r && !rb && fv && (m_rob > 0) && (ls ? (m_lsb > 0) : (m_rs > 0));
        s_grant = issue_grant; s_alias = alias_2disp;
        s_srob = stall_rob; s_srs = stall_rs; s_slsb = stall_lsb;
        check("model_grant", 32'(issue_grant), 32'(eg));
        check("model_alias", 32'(alias_2disp), 32'(m_alias));
        check("model_stall_rob", 32'(stall_rob), 32'(fv && run && m_rob == 0));
        check("model_stall_rs", 32'(stall_rs), 32'(fv && run && !ls && m_rs == 0));
        check("model_stall_lsb", 32'(stall_lsb), 32'(fv && run && ls && m_lsb == 0));
        if (alias_2disp == '0) check("alias_nonzero", 32'(alias_2disp), 32'(m_alias));
        if (r) begin
            if (rb) begin
                m_rob = ROB_SIZE - 1; m_rs = RS_SIZE; m_lsb = LSB_SIZE;
                m_alias = 1; m_hold = FLUSH_CYCLES;
            end else if (!run) begin
                m_hold--;
            end else begin
                m_rob = m_rob - int'(eg) + int'(cm);
                if (m_rob > ROB_SIZE - 1) m_rob = ROB_SIZE - 1;
                m_rs = m_rs - int'(eg && !ls) + int'(rsr);
                if (m_rs > RS_SIZE) m_rs = RS_SIZE;
                m_lsb = m_lsb - int'(eg && ls) + int'(lsr);
                if (m_lsb > LSB_SIZE) m_lsb = LSB_SIZE;
                if (eg) m_alias = (m_alias == ROB_SIZE - 1) ? 1 : m_alias + 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Assert reset away from any edge and check outputs before the next
    // edge, then release it with the fetcher idle.
    task automatic do_reset();
        rst_n = 1'b0;
        rdy = 1'b1; rollback_signal = 1'b0; fet_valid = 1'b1; fet_opcode = OP_RS;
        rob_commit = 1'b0; rs_release = 1'b0; lsb_release = 1'b0;
        #2;
        check("rst_grant", 32'(issue_grant), 32'd0);
        check("rst_alias", 32'(alias_2disp), 32'd1);
        check("rst_stalls", {29'd0, stall_rob, stall_rs, stall_lsb}, 32'd0);
        fet_valid = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        bit         r, rb, fv;
        logic [6:0] opc;
        bit         cm, rsr, lsr;
        bit         g;
        int         alias_v;
        bit         srob, srs, slsb;
    } vec_t;

    vec_t tab[$];
    int   ngr;
    int   first;

    initial begin
        // ---------------- table-driven directed vectors -------------------
        //                r rb fv opc    cm rs ls  g  alias srob srs slsb
        tab.push_back('{1, 0, 1, OP_RS, 0, 0, 0, 1, 1, 0, 0, 0});
        tab.push_back('{1, 0, 1, OP_RS, 0, 0, 0, 1, 2, 0, 0, 0});
        tab.push_back('{1, 0, 1, OP_RS, 0, 0, 0, 1, 3, 0, 0, 0});
        tab.push_back('{1, 0, 0, OP_RS, 0, 0, 0, 0, 4, 0, 0, 0});
        tab.push_back('{0, 0, 1, OP_RS, 0, 0, 0, 0, 4, 0, 0, 0});
        tab.push_back('{0, 0, 1, OP_RS, 1, 1, 0, 0, 4, 0, 0, 0});
        tab.push_back('{0, 0, 1, OP_LD, 0, 0, 0, 0, 4, 0, 0, 0});
        tab.push_back('{0, 0, 1, OP_RS, 0, 0, 0, 0, 4, 0, 0, 0});
        tab.push_back('{1, 0, 1, OP_LD, 0, 0, 0, 1, 4, 0, 0, 0});
        tab.push_back('{1, 1, 1, OP_RS, 0, 0, 0, 0, 5, 0, 0, 0});
        tab.push_back('{1, 0, 1, OP_RS, 0, 0, 0, 0, 1, 0, 0, 0});
        tab.push_back('{1, 0, 1, OP_RS, 0, 0, 0, 0, 1, 0, 0, 0});
        tab.push_back('{1, 0, 1, OP_RS, 0, 0, 0, 1, 1, 0, 0, 0});
        tab.push_back('{1, 0, 1, OP_ST, 0, 0, 0, 1, 2, 0, 0, 0});

        @(posedge clk);
        #1;
        do_reset();
        foreach (tab[i]) begin
            step(tab[i].r, tab[i].rb, tab[i].fv, tab[i].opc, tab[i].cm, tab[i].rsr, tab[i].lsr);
            check($sformatf("tab%0d_grant", i), 32'(s_grant), 32'(tab[i].g));
            check($sformatf("tab%0d_alias", i), 32'(s_alias), 32'(tab[i].alias_v));
            check($sformatf("tab%0d_stalls", i), {29'd0, s_srob, s_srs, s_slsb},
                  {29'd0, tab[i].srob, tab[i].srs, tab[i].slsb});
        end

        // ---------------- LSB exhaustion and release visibility -----------
        do_reset();
        for (int i = 0; i < LSB_SIZE; i++) begin
            step(1, 0, 1, OP_ST, 0, 0, 0);
            check("lsb_fill_grant", 32'(s_grant), 32'd1);
            check("lsb_fill_alias", 32'(s_alias), 32'(i + 1));
        end
        step(1, 0, 1, OP_ST, 0, 0, 0);
        check("lsb_full_grant", 32'(s_grant), 32'd0);
        check("lsb_full_stall", 32'(s_slsb), 32'd1);
        check("lsb_full_no_rob_stall", 32'(s_srob), 32'd0);
        step(1, 0, 1, OP_ST, 0, 0, 1);
        check("lsb_release_same_cycle", 32'(s_grant), 32'd0);
        step(1, 0, 1, OP_ST, 0, 0, 0);
        check("lsb_release_next_cycle", 32'(s_grant), 32'd1);
        check("lsb_release_alias", 32'(s_alias), 32'd9);

        // ---------------- grant and release on the same counter -----------
        do_reset();
        for (int i = 0; i < RS_SIZE - 5; i++) step(1, 0, 1, OP_RS, 1, 0, 0);
        step(1, 0, 1, OP_RS, 1, 1, 0);
        check("rs_same_cycle_grant", 32'(s_grant), 32'd1);
        ngr = 0;
        for (int i = 0; i < 6; i++) begin
            step(1, 0, 1, OP_RS, 1, 0, 0);
            ngr += int'(s_grant);
        end
        check("rs_left_after_same_cycle", 32'(ngr), 32'd5);
        check("rs_empty_stall", 32'(s_srs), 32'd1);

        // ---------------- alias wrap and ROB exhaustion -------------------
        do_reset();
        for (int i = 0; i < ROB_SIZE - 1; i++) begin
            step(1, 0, 1, OP_RS, 0, 1, 0);
            check("wrap_alias_seq", 32'(s_alias), 32'(i + 1));
        end
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 1, OP_RS, 0, 0, 0);
            check("rob_empty_grant", 32'(s_grant), 32'd0);
            check("rob_empty_stall", 32'(s_srob), 32'd1);
            check("wrap_alias_1", 32'(s_alias), 32'd1);
        end
        step(1, 0, 1, OP_RS, 1, 0, 0);
        check("rob_commit_same_cycle", 32'(s_grant), 32'd0);
        step(1, 0, 1, OP_RS, 0, 0, 0);
        check("rob_commit_next_grant", 32'(s_grant), 32'd1);
        check("rob_commit_alias", 32'(s_alias), 32'd1);

        // ---------------- double rollback extends the drain ---------------
        do_reset();
        step(1, 0, 1, OP_RS, 0, 0, 0);
        step(1, 1, 1, OP_RS, 0, 0, 0);   // relative cycle 0
        step(1, 1, 1, OP_RS, 0, 1, 1);   // relative cycle 1
        first = -1;
        for (int c = 2; c < 12 && first < 0; c++) begin
            step(1, 0, 1, OP_RS, 0, 0, 0);
            if (s_grant) begin
                first = c;
                check("drain_first_alias", 32'(s_alias), 32'd1);
            end
        end
        check("drain_first_grant_cycle", 32'(first), 32'd4);

        // ---------------- reset mid-stream --------------------------------
        for (int i = 0; i < 5; i++) step(1, 0, 1, OP_LD, 0, 0, 0);
        do_reset();

        // ---------------- randomized traffic ------------------------------
        for (int i = 0; i < 3000; i++) begin
            logic [6:0] opc;
            case ($urandom_range(0, 3))
                0:       opc = OP_LD;
                1:       opc = OP_ST;
                2:       opc = OP_RS;
                default: opc = 7'($urandom);
            endcase
            step($urandom_range(0, 7) != 0, $urandom_range(0, 29) == 0,
                 $urandom_range(0, 3) != 0, opc,
                 $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 2) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/issue_credit_ctrl.md
# issue_credit_ctrl

Issue-side flow controller between the instruction fetcher and the dispatcher. It holds free-slot credits for the ROB, reservation station and load/store buffer. It grants a fetched instruction entry to dispatch only when every structure it needs has a free slot, and it hands out the ROB alias for that instruction. It also enforces the drain window after a rollback.

## Interface
- `ROB_SIZE`, default 16: ROB entries; alias 0 is reserved (`RENAMED_ZERO`), so ROB capacity is ROB_SIZE-1.
- `RS_SIZE`, default 16: reservation-station entries.
- `LSB_SIZE`, default 16: load/store-buffer entries.
- `FLUSH_CYCLES`, default 2: cycles in which grant is held low after rollback; legal range 1..7.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `rdy`  in  1  global ready; low freezes all state.
- `rollback_signal`  in  1  misprediction flush from the ROB.
- `fet_valid`  in  1  fetcher holds an instruction.
- `fet_opcode`  in  7  instr[6:0] of that instruction.
- `issue_grant`  out  1  instruction accepted this cycle; drives the dispatcher's `valid_from_fet`.
- `alias_2disp`  out  $clog2(ROB_SIZE)  ROB id for the granted instruction (`id_from_rob`).
- `rob_commit`  in  1  one ROB entry retired.
- `rs_release`  in  1  one RS entry issued to the ALU.
- `lsb_release`  in  1  one LSB entry completed.
- `stall_rob`, `stall_rs`, `stall_lsb`  out  1 each  stall reason, for debug.

## Operation
- Class: fet_opcode 0000011 (load) or 0100011 (store) selects LS; every other opcode selects RS. Every instruction needs one ROB credit.
- Credit counters: rob_cnt has range 0..ROB_SIZE-1, rs_cnt 0..RS_SIZE, lsb_cnt 0..LSB_SIZE. Each counter is `$clog2(max)+1` bits wide.
- Grant condition: `issue_grant = state==RUN & rdy & !rollback_signal & fet_valid & rob_cnt!=0 & (LS ? lsb_cnt!=0 : rs_cnt!=0)`. The signal is combinational from registered state.
- Counter update per cycle: next = cnt - take + release.
  - take is 1 on a grant that consumes that resource.
  - If a grant and a release hit the same counter in the same cycle, the counter is unchanged.
  - A release when cnt==max is a protocol violation. The counter saturates at max.
- Alias pointer:
  - Reset value is 1.
  - Advances by 1 on each grant, wrapping from ROB_SIZE-1 to 1; the value 0 is never issued.
  - `alias_2disp` is the current pointer, registered.
- FSM states:
  - RUN: normal issue.
  - DRAIN: `rollback_signal` (with rdy high) in any state moves to DRAIN. Counters reset to full, the alias pointer resets to 1 and drain_cnt is loaded with FLUSH_CYCLES-1. Grant is held 0.
  - DRAIN to RUN: when drain_cnt==0. Otherwise drain_cnt is decremented.
  - A rollback during DRAIN reloads drain_cnt.
  - Releases arriving during DRAIN or in the rollback cycle are ignored.
- Stall flags, valid when `fet_valid & state==RUN`:
  - stall_rob = rob_cnt==0.
  - stall_rs = RS class and rs_cnt==0.
  - stall_lsb = LS class and lsb_cnt==0.
  - Any of the three may be asserted together.
- rdy low: no grant, no counter, pointer or FSM change. Releases are not lost, because producers also stall on rdy.

## Timing
- Reset values:
  - State RUN.
  - rob_cnt = ROB_SIZE-1, rs_cnt = RS_SIZE, lsb_cnt = LSB_SIZE.
  - Alias pointer 1, `alias_2disp` 1.
  - `issue_grant` 0 and all stall flags 0 while reset is asserted.
- Grant latency: 0 cycles from fet_valid when credits are available. The credit is consumed at the same edge.
- Visibility of a release: a release at edge N makes a new grant possible in cycle N+1.
- Dispatcher registers the grant one cycle later; the credit is already reserved, so no over-subscription.
- After a rollback pulse in cycle N, the first possible grant is in cycle N+FLUSH_CYCLES+1.
- Reset asserted mid-operation: all state returns to the reset values immediately, without waiting for a clock edge.

## Configuration
- `ISSUE_CTRL_STATS_EN` defined:
  - Adds 32-bit wrapping counters `stat_grants`, `stat_stall_rob`, `stat_stall_rs`, `stat_stall_lsb` and `stat_flushes`, exposed as outputs.
  - Each increments on its event while rdy is high.
  - Cleared only by reset, not by rollback.
- `ISSUE_CTRL_STATS_EN` undefined: the ports and logic are absent. The remaining behaviour is identical.

## Structure
- Shared package holds:
  - Opcode constants (`OPC_LOAD`, `OPC_STORE`).
  - `RENAMED_ZERO`.
  - The ROB id width, also used by the dispatcher, ROB and register file.
  - The FSM state enum {RUN, DRAIN}.
- One sub-module, `credit_counter` (parameter MAX; inputs take, release, reload; outputs cnt and nonzero), instantiated three times. The FSM and alias pointer stay in the top level.

## Test plan
- Reset, then fet_valid=1 with opcode 0110011 for 3 cycles → grant on all 3 cycles, aliases 1,2,3, rs_cnt=13, rob_cnt=12.
- 8 stores with no releases and LSB_SIZE=8 → first 8 granted; the 9th sees stall_lsb=1 and grant=0. One lsb_release → grant in the next cycle.
- Grant an RS instruction and pulse rs_release in the same cycle at rs_cnt=5 → rs_cnt stays 5.
- 15 grants → alias wraps 15 then 1 and never 0. With rob_cnt=0, stall_rob=1 until rob_commit.
- Rollback in cycle 10 with FLUSH_CYCLES=2 → grant 0 in cycles 10–12, first grant in cycle 13 with alias 1 and full counters. A second rollback in cycle 11 pushes the first grant to cycle 14.
- rdy low for 4 cycles with fet_valid=1 → no grant, counters unchanged. Then assert rst_n=0 mid-stream → outputs return to reset values before the next clock edge.
